// File: rtl/axi_rd_burst_ctrl.sv
// axi_rd_burst_ctrl
// AXI4 slave read-channel sequencer. Accepts one AR transaction at a time,
// walks the FIXED/INCR/WRAP address sequence and issues one single-word
// memory read per beat, returning each beat on the R channel. Illegal
// bursts are answered with SLVERR beats and never touch memory.
module axi_rd_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_BITS   = 8,
  parameter int SIZE_BITS  = 3,
  parameter int ID_BITS    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // AR channel
  input  logic                  i_arvalid,
  output logic                  o_arready,
  input  logic [ID_BITS-1:0]    i_arid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [LEN_BITS-1:0]   i_arlen,
  input  logic [SIZE_BITS-1:0]  i_arsize,
  input  logic [1:0]            i_arburst,
  // R channel
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [ID_BITS-1:0]    o_rid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  // Memory read port
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_err
);

  // Largest legal ARSIZE: one beat may not be wider than the data bus.
  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of legal WRAP lengths: 2, 4, 8 and 16 beats.
  localparam int NUM_WRAP_LENS = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t                r_state;
  logic [ID_BITS-1:0]    r_id;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [LEN_BITS-1:0]   r_len;
  logic [LEN_BITS-1:0]   r_beat_cnt;
  logic [SIZE_BITS-1:0]  r_size;
  logic [1:0]            r_burst;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic                  r_mem_req;

  logic [NUM_WRAP_LENS-1:0] w_wrap_len_hit;
  logic                     w_wrap_len_ok;
  logic                     w_size_bad;
  logic                     w_ar_illegal;
  logic                     w_last_beat;
  logic [ADDR_WIDTH-1:0]    w_incr;
  logic [ADDR_WIDTH-1:0]    w_aligned;
  logic [ADDR_WIDTH-1:0]    w_step;
  logic [ADDR_WIDTH-1:0]    w_wrap_bound;
  logic [ADDR_WIDTH-1:0]    w_wrap_mask;
  logic [ADDR_WIDTH-1:0]    w_wrap_next;
  logic [ADDR_WIDTH-1:0]    w_next_addr;

  // WRAP is only defined for 2, 4, 8 or 16 beats, i.e. arlen = 2^(gi+1)-1.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WRAP_LENS; gi++) begin : g_wrap_len
      assign w_wrap_len_hit[gi] = (i_arlen == LEN_BITS'((1 << (gi + 1)) - 1));
    end
  endgenerate

  assign w_wrap_len_ok = |w_wrap_len_hit;
  assign w_size_bad    = (i_arsize > SIZE_BITS'(MAX_SIZE));
  assign w_ar_illegal  = (i_arburst == BURST_RSVD) || w_size_bad ||
                         ((i_arburst == BURST_WRAP) && !w_wrap_len_ok);

  assign w_last_beat   = (r_beat_cnt == r_len);

  // Address of the following beat. INCR realigns to the beat size from the
  // second beat on; WRAP keeps the upper bits fixed and wraps the offset
  // inside a (len+1)*bytes window.
  assign w_incr       = ADDR_WIDTH'(1) << r_size;
  assign w_aligned    = r_cur_addr & ~(w_incr - ADDR_WIDTH'(1));
  assign w_step       = w_aligned + w_incr;
  assign w_wrap_bound = (ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size;
  assign w_wrap_mask  = w_wrap_bound - ADDR_WIDTH'(1);
  assign w_wrap_next  = (r_cur_addr & ~w_wrap_mask) | (w_step & w_wrap_mask);

  // Select the next-beat address for the latched burst type.
  always_comb begin
    w_next_addr = r_cur_addr;
    case (r_burst)
      BURST_FIXED: w_next_addr = r_cur_addr;
      BURST_INCR:  w_next_addr = w_step;
      BURST_WRAP:  w_next_addr = w_wrap_next;
      default:     w_next_addr = r_cur_addr;
    endcase
  end

  // Burst sequencer: one memory read per beat, then one R beat, strictly
  // alternating so a memory request never overlaps a pending R beat.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_id       <= '0;
      r_cur_addr <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_mem_req  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_arvalid) begin
            r_id       <= i_arid;
            r_cur_addr <= i_araddr;
            r_len      <= i_arlen;
            r_size     <= i_arsize;
            r_burst    <= i_arburst;
            r_beat_cnt <= '0;
            if (w_ar_illegal) begin
              // Error beats carry no data; the first one is presented at once.
              r_state  <= S_ERR;
              r_rvalid <= 1'b1;
              r_rdata  <= '0;
              r_rresp  <= RESP_SLVERR;
              r_rlast  <= (i_arlen == '0);
            end else begin
              r_state   <= S_REQ;
              r_mem_req <= 1'b1;
            end
          end
        end

        S_REQ: begin
          // i_mem_rvalid doubles as the grant, so the request holds until it.
          if (i_mem_rvalid) begin
            r_rdata   <= i_mem_rdata;
            r_rresp   <= i_mem_err ? RESP_SLVERR : RESP_OKAY;
            r_mem_req <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rlast   <= w_last_beat;
            r_state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (i_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (w_last_beat) begin
              r_state <= S_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + LEN_BITS'(1);
              r_cur_addr <= w_next_addr;
              r_mem_req  <= 1'b1;
              r_state    <= S_REQ;
            end
          end
        end

        S_ERR: begin
          if (i_rready) begin
            if (w_last_beat) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              // Next error beat follows back-to-back; rdata/rresp stay as set.
              r_beat_cnt <= r_beat_cnt + LEN_BITS'(1);
              r_rlast    <= ((r_beat_cnt + LEN_BITS'(1)) == r_len);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // AR is only offered while idle and out of reset.
  assign o_arready  = (r_state == S_IDLE) && i_rst_n;

  assign o_rvalid   = r_rvalid;
  assign o_rid      = r_id;
  assign o_rdata    = r_rdata;
  assign o_rresp    = r_rresp;
  assign o_rlast    = r_rlast;
  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_cur_addr;

endmodule
